// File: rtl/mul_div_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface mul_div_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
);
  logic                  start;
  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (output start, op, operand_a, operand_b, flush,
                  input  busy, done, result);
  modport slave  (input  start, op, operand_a, operand_b, flush,
                  output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide: one shift-add or restoring-divide step per cycle,
// with a single-cycle path for divide-by-zero and signed overflow.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input logic      clk,
  input logic      rst_n,
  mul_div_if.slave bus
);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(7);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [CNT_W-1:0]      cnt;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  neg_q;

  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                      input logic neg);
    return neg ? -v : v;
  endfunction

  // Apply the deferred sign to the unsigned product or quotient/remainder pair.
  function automatic logic [DATA_WIDTH-1:0] finalize(input logic [OP_WIDTH-1:0]   op,
                                                     input logic                  neg,
                                                     input logic [DATA_WIDTH-1:0] hi,
                                                     input logic [DATA_WIDTH-1:0] lo);
    logic [PROD_W-1:0] prod;
    prod = neg ? -{hi, lo} : {hi, lo};
    case (op)
      OP_MUL:                       return prod[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return prod[PROD_W-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:              return neg ? -lo : lo;
      default:                      return neg ? -hi : hi;
    endcase
  endfunction

  logic                  a_signed, b_signed, sa, sb, is_div, is_rem;
  logic                  div_zero, div_ovf, fast;
  logic [DATA_WIDTH-1:0] mag_a, mag_b, fast_res;

  // Request decode, evaluated on the live inputs while the unit is ready.
  always_comb begin
    a_signed = bus.op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = bus.op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    is_div   = bus.op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_rem   = bus.op inside {OP_REM, OP_REMU};
    sa       = a_signed && ($signed(bus.operand_a) < 0);
    sb       = b_signed && ($signed(bus.operand_b) < 0);
    mag_a    = magnitude(bus.operand_a, sa);
    mag_b    = magnitude(bus.operand_b, sb);
    div_zero = is_div && (bus.operand_b == '0);
    div_ovf  = (bus.op inside {OP_DIV, OP_REM}) &&
               (bus.operand_a == MOST_NEG) && (bus.operand_b == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = is_rem ? bus.operand_a : '1;
    else          fast_res = is_rem ? '0 : bus.operand_a;
  end

  logic                  op_is_div;
  logic [DATA_WIDTH:0]   add_sum, shifted, trial;
  logic [DATA_WIDTH-1:0] hi_n, lo_n;

  // hi/lo hold {product high, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    op_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted   = {hi_q, lo_q[DATA_WIDTH-1]};
    trial     = shifted - {1'b0, opnd_q};
    if (op_is_div) begin
      hi_n = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
      lo_n = {lo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
    end else begin
      hi_n = add_sum[DATA_WIDTH:1];
      lo_n = {add_sum[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cnt      <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
    end else if (bus.flush) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.op;
            neg_q  <= is_rem ? sa : (sa ^ sb);
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= is_div ? mag_a : mag_b;
            opnd_q <= is_div ? mag_b : mag_a;
            if (fast) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= fast_res;
            end else begin
              state  <= CALC;
              busy_q <= 1'b1;
            end
          end
        end
        CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= finalize(op_q, neg_q, hi_n, lo_n);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_mul_div_unit;
  localparam int DW  = 32;
  localparam int OW  = 3;
  localparam int LAT = DW + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mul_div_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();
  mul_div_unit #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int          checks    = 0;
  int          passes    = 0;
  int          cyc       = 0;
  int          done_seen = 0;
  bit          pend      = 1'b0;
  int          fin       = 0;
  logic [31:0] pend_res  = '0;
  logic [31:0] exp_result = '0;
  bit          exp_busy, exp_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference arithmetic straight from the instruction definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [63:0] up;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op >= 3'd4) && ((b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Transaction model: an accepted request completes at a known cycle unless flushed or reset.
  always @(posedge clk) begin
    if (!rst_n) pend = 1'b0;
    else if (bus.flush) pend = 1'b0;
    else if (bus.start && (!pend || cyc == fin)) begin
      pend_res = ref_result(bus.op, bus.operand_a, bus.operand_b);
      fin      = cyc + (ref_fast(bus.op, bus.operand_a, bus.operand_b) ? 1 : LAT);
      pend     = 1'b1;
    end else if (pend && cyc == fin) pend = 1'b0;
    cyc = cyc + 1;
  end

  always @(negedge rst_n) begin
    pend       = 1'b0;
    exp_result = '0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_done = pend && (cyc == fin);
      exp_busy = pend && (cyc < fin);
      if (exp_done) exp_result = pend_res;
      if (bus.done) done_seen++;
      check("cycle outputs", 64'({bus.busy, bus.done, bus.result}),
            64'({exp_busy, exp_done, exp_result}));
    end
  end

  task automatic wait_done(output int c);
    bit got;
    got = 1'b0;
    c   = -1;
    for (int i = 0; i < LAT + 8 && !got; i++) begin
      @(negedge clk);
      if (bus.done) begin got = 1'b1; c = cyc; end
    end
  endtask

  task automatic scramble();
    bus.op        = 3'($urandom);
    bus.operand_a = 32'($urandom);
    bus.operand_b = 32'($urandom);
  endtask

  task automatic run_op(input string name, input bit now, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res);
    int t0, dc;
    if (!now) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
    wait_done(dc);
    check({name, " latency"}, 64'((dc < 0) ? -1 : dc - t0), 64'(exp_lat));
    check({name, " result"}, 64'(bus.result), 64'(exp_res));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, n, d1, d2;
    bus.start = 1'b0; bus.flush = 1'b0;
    bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset outputs", 64'({bus.busy, bus.done, bus.result}), 64'(0));
    @(negedge clk) rst_n = 1'b1;

    run_op("MUL 7*-3",         1'b1, 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);
    run_op("MULHU -1*-1",      1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    run_op("MULH -1*-1",       1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000);
    run_op("MULHSU -1*max",    1'b0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF);
    run_op("DIV -7/2",         1'b0, 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD);
    run_op("REM -7/2",         1'b0, 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF);
    run_op("DIVU big/16",      1'b0, 3'd5, 32'h8000_0000, 32'h0000_0010, 33, 32'h0800_0000);
    run_op("DIVU 5/0",         1'b0, 3'd5, 32'h0000_0005, 32'h0000_0000, 1,  32'hFFFF_FFFF);
    run_op("REM 5/0",          1'b0, 3'd6, 32'h0000_0005, 32'h0000_0000, 1,  32'h0000_0005);
    run_op("DIV ovf",          1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000);
    run_op("REM ovf",          1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h0000_0000);
    run_op("REMU 100/7",       1'b0, 3'd7, 32'd100,       32'd7,         33, 32'h0000_0002);
    run_op("DIV 7/-2",         1'b0, 3'd4, 32'd7,         32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    run_op("MUL x16",          1'b0, 3'd0, 32'h1234_5678, 32'h0000_0010, 33, 32'h2345_6780);

    // Flush ten cycles into a multiply.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd0; bus.operand_a = 32'd3; bus.operand_b = 32'd5;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush idle next cycle", 64'({bus.busy, bus.done}), 64'(0));
    check("flush cycle number", 64'(cyc - t0), 64'(11));
    n = done_seen;
    repeat (LAT + 5) @(posedge clk); #1;
    check("flush no done", 64'(done_seen - n), 64'(0));
    check("flush result kept", 64'(bus.result), 64'(32'h2345_6780));

    // Start and flush together: the request is dropped.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.operand_a = 32'd9; bus.operand_b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n = done_seen;
    repeat (LAT + 5) @(posedge clk); #1;
    check("start+flush ignored", 64'(done_seen - n), 64'(0));
    check("start+flush result", 64'(bus.result), 64'(32'h2345_6780));

    // Reset during a divide.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd4; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check("async reset outputs", 64'({bus.busy, bus.done, bus.result}), 64'(0));
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    n = done_seen;
    repeat (LAT + 5) @(posedge clk); #1;
    check("no done after reset", 64'(done_seen - n), 64'(0));

    // Back-to-back: second request issued during the first done cycle.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd0; bus.operand_a = 32'd7; bus.operand_b = 32'hFFFF_FFFD;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
    wait_done(d1);
    check("b2b first result", 64'(bus.result), 64'(32'hFFFF_FFEB));
    bus.start = 1'b1; bus.op = 3'd5; bus.operand_a = 32'h8000_0000; bus.operand_b = 32'h10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
    wait_done(d2);
    check("b2b first done cycle", 64'((d1 < 0) ? -1 : d1 - t0), 64'(33));
    check("b2b second done cycle", 64'((d2 < 0) ? -1 : d2 - t0), 64'(66));
    check("b2b second result", 64'(bus.result), 64'(32'h0800_0000));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width in bits (equal to ALU data width).
REQ-002 Parameter OP_WIDTH, default 3, width of op select.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only when unit is ready (IDLE or DONE).
REQ-006 op  input  OP_WIDTH  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 operand_a  input  DATA_WIDTH  rs1 value / dividend.
REQ-008 operand_b  input  DATA_WIDTH  rs2 value / divisor.
REQ-009 flush  input  1  abort in-flight operation (pipeline redirect).
REQ-010 busy  output  1  high while iterating; EX stage stalls on busy.
REQ-011 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-012 result  output  DATA_WIDTH  operation result, muxed with ALU output_data downstream.

Function
REQ-013 The unit SHALL be an FSM with states IDLE, CALC, DONE.
REQ-014 IDLE/DONE with start=1 and flush=0 SHALL latch op, operand_a, operand_b and go to CALC, iteration counter = 0; later input changes SHALL have no effect.
REQ-015 CALC SHALL perform one iteration per cycle for exactly DATA_WIDTH cycles, then enter DONE.
REQ-016 Latency: start in cycle 0 -> busy high cycles 1..DATA_WIDTH -> done high and result valid in cycle DATA_WIDTH+1 (33 at default).
REQ-017 DONE SHALL last one cycle, then IDLE unless a new start is accepted (back-to-back issue allowed, no bubble).
REQ-018 Multiply: shift-add on 2*DATA_WIDTH product of sign/zero-extended magnitudes; MUL returns low half, MULH/MULHSU/MULHU return high half with signed x signed, signed x unsigned, unsigned x unsigned.
REQ-019 Divide: restoring division on magnitudes; signed quotient negated when operand signs differ; signed remainder takes dividend sign.
REQ-020 Divisor zero: quotient all ones, remainder = dividend; handled via fast path.
REQ-021 Signed overflow (DIV/REM, dividend = most negative, divisor = -1): quotient = dividend, remainder 0; fast path.
REQ-022 Fast path: IDLE/DONE -> DONE directly; done in cycle 1, busy never asserted.
REQ-023 result SHALL hold its last value until the next done; it is updated only in the done cycle.
REQ-024 flush=1 SHALL force IDLE next edge from any state, drop done, leave result unchanged; flush and start together: flush wins, start ignored.
REQ-025 done and busy SHALL never be high in the same cycle.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, counter=0, latched operands 0, regardless of clock.
REQ-027 Reset asserted mid-CALC SHALL abandon the operation; no done after reset release.
REQ-028 After rst_n deassertion, the first start SHALL be accepted at the next rising edge.

Verification
REQ-029 MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> busy cycles 1..32, done cycle 33, result 0xFFFFFFEB.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0x80000000/0x10 -> 0x08000000.
REQ-032 DIVU 5/0 -> done cycle 1, result 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> done cycle 1, result 0x80000000.
REQ-033 start MUL, flush at cycle 10 -> IDLE cycle 11, no done, result unchanged; start+flush same cycle -> ignored.
REQ-034 rst_n low at cycle 15 of a DIV -> busy=0, done=0, result=0 at once; two back-to-back starts (second in DONE cycle) -> done cycles 33 and 66.
